// File: rtl/id_operand_stage.sv
// MIPS32 operand-fetch stage: register-file read, EX/MEM forwarding, immediate select,
// load-use bubble insertion and the ID/EX pipeline register.
module id_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_rs_en,
  input  logic              id_rt_en,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_use_imm,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [7:0]        id_aluop,
  input  logic              id_wreg,
  input  logic [ADDR_W-1:0] id_wd,
  input  logic              id_is_load,
  output logic              reg_rd_en1,
  output logic              reg_rd_en2,
  output logic [ADDR_W-1:0] reg_rdaddr1,
  output logic [ADDR_W-1:0] reg_rdaddr2,
  input  logic [DATA_W-1:0] reg_rddata1,
  input  logic [DATA_W-1:0] reg_rddata2,
  input  logic              fwd_ex_wreg,
  input  logic [ADDR_W-1:0] fwd_ex_wd,
  input  logic [DATA_W-1:0] fwd_ex_wdata,
  input  logic              fwd_ex_is_load,
  input  logic              fwd_mem_wreg,
  input  logic [ADDR_W-1:0] fwd_mem_wd,
  input  logic [DATA_W-1:0] fwd_mem_wdata,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              stall_req,
  output logic              idex_valid,
  output logic [7:0]        idex_aluop,
  output logic [DATA_W-1:0] idex_op1,
  output logic [DATA_W-1:0] idex_op2,
  output logic              idex_wreg,
  output logic [ADDR_W-1:0] idex_wd,
  output logic              idex_is_load,
  output logic [CNT_W-1:0]  perf_bubbles
);

  logic [DATA_W-1:0] op1_res;
  logic [DATA_W-1:0] op2_res;
  logic              rs_hit;
  logic              rt_hit;
  logic              load_use;

  assign reg_rd_en1  = id_valid & id_rs_en;
  assign reg_rdaddr1 = id_rs_addr;
  assign reg_rd_en2  = id_valid & id_rt_en & ~id_use_imm;
  assign reg_rdaddr2 = id_rt_addr;

  // A load in EX has no data yet, so it is never a forwarding source.
  function automatic logic [DATA_W-1:0] resolve(input logic              en,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] rf_data);
    if (!en || addr == '0) begin
      return '0;
    end else if (fwd_ex_wreg && fwd_ex_wd == addr && !fwd_ex_is_load) begin
      return fwd_ex_wdata;
    end else if (fwd_mem_wreg && fwd_mem_wd == addr) begin
      return fwd_mem_wdata;
    end else begin
      return rf_data;
    end
  endfunction

  always_comb begin
    op1_res = resolve(id_rs_en, id_rs_addr, reg_rddata1);
    op2_res = id_use_imm ? id_imm : resolve(id_rt_en, id_rt_addr, reg_rddata2);
  end

  assign rs_hit   = id_rs_en && fwd_ex_wd == id_rs_addr;
  assign rt_hit   = id_rt_en && !id_use_imm && fwd_ex_wd == id_rt_addr;
  assign load_use = id_valid && fwd_ex_is_load && fwd_ex_wreg && fwd_ex_wd != '0
                    && (rs_hit || rt_hit);

  assign stall_req = load_use | ex_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid   <= 1'b0;
      idex_aluop   <= '0;
      idex_op1     <= '0;
      idex_op2     <= '0;
      idex_wreg    <= 1'b0;
      idex_wd      <= '0;
      idex_is_load <= 1'b0;
      perf_bubbles <= '0;
    end else if (flush || (!ex_stall && load_use)) begin
      idex_valid   <= 1'b0;
      idex_aluop   <= '0;
      idex_op1     <= '0;
      idex_op2     <= '0;
      idex_wreg    <= 1'b0;
      idex_wd      <= '0;
      idex_is_load <= 1'b0;
      // Only a genuine load-use bubble is counted; flush takes precedence.
      if (!flush && perf_bubbles != '1) begin
        perf_bubbles <= perf_bubbles + 1'b1;
      end
    end else if (!ex_stall) begin
      idex_valid   <= id_valid;
      idex_aluop   <= id_aluop;
      idex_op1     <= op1_res;
      idex_op2     <= op2_res;
      idex_wreg    <= id_wreg;
      idex_wd      <= id_wd;
      idex_is_load <= id_is_load;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: forwarding priority, load-use bubble, stall/flush/reset,
// and bubble-counter saturation.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_en, id_rt_en, id_use_imm, id_wreg, id_is_load;
  logic [4:0]  id_rs_addr, id_rt_addr, id_wd;
  logic [31:0] id_imm;
  logic [7:0]  id_aluop;
  logic        reg_rd_en1, reg_rd_en2;
  logic [4:0]  reg_rdaddr1, reg_rdaddr2;
  logic [31:0] reg_rddata1, reg_rddata2;
  logic        fwd_ex_wreg, fwd_ex_is_load, fwd_mem_wreg;
  logic [4:0]  fwd_ex_wd, fwd_mem_wd;
  logic [31:0] fwd_ex_wdata, fwd_mem_wdata;
  logic        ex_stall, flush, stall_req;
  logic        idex_valid, idex_wreg, idex_is_load;
  logic [7:0]  idex_aluop;
  logic [31:0] idex_op1, idex_op2;
  logic [4:0]  idex_wd;
  logic [15:0] perf_bubbles;

  int tests = 0;
  int fails = 0;

  id_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_use_imm(id_use_imm), .id_imm(id_imm), .id_aluop(id_aluop),
    .id_wreg(id_wreg), .id_wd(id_wd), .id_is_load(id_is_load),
    .reg_rd_en1(reg_rd_en1), .reg_rd_en2(reg_rd_en2),
    .reg_rdaddr1(reg_rdaddr1), .reg_rdaddr2(reg_rdaddr2),
    .reg_rddata1(reg_rddata1), .reg_rddata2(reg_rddata2),
    .fwd_ex_wreg(fwd_ex_wreg), .fwd_ex_wd(fwd_ex_wd), .fwd_ex_wdata(fwd_ex_wdata),
    .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_mem_wreg(fwd_mem_wreg), .fwd_mem_wd(fwd_mem_wd), .fwd_mem_wdata(fwd_mem_wdata),
    .ex_stall(ex_stall), .flush(flush), .stall_req(stall_req),
    .idex_valid(idex_valid), .idex_aluop(idex_aluop), .idex_op1(idex_op1),
    .idex_op2(idex_op2), .idex_wreg(idex_wreg), .idex_wd(idex_wd),
    .idex_is_load(idex_is_load), .perf_bubbles(perf_bubbles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    fwd_ex_wreg = 0; fwd_ex_wd = 0; fwd_ex_wdata = 0; fwd_ex_is_load = 0;
    fwd_mem_wreg = 0; fwd_mem_wd = 0; fwd_mem_wdata = 0;
  endtask

  initial begin
    rst = 1; ex_stall = 0; flush = 0;
    id_valid = 0; id_rs_en = 0; id_rt_en = 0; id_use_imm = 0; id_wreg = 0; id_is_load = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_wd = 0; id_imm = 0; id_aluop = 0;
    reg_rddata1 = 0; reg_rddata2 = 0;
    clr_fwd();
    step(); step();
    chk("reset_valid", 32'(idex_valid), 32'h0);
    chk("reset_op1", idex_op1, 32'h0);
    chk("reset_perf", 32'(perf_bubbles), 32'h0);
    chk("idle_stall_req", 32'(stall_req), 32'h0);
    rst = 0;

    // Plain read: ADD rs=3 rt=4
    id_valid = 1; id_rs_en = 1; id_rt_en = 1; id_rs_addr = 3; id_rt_addr = 4;
    id_aluop = 8'h20; id_wreg = 1; id_wd = 6;
    reg_rddata1 = 32'h11; reg_rddata2 = 32'h22;
    #1;
    chk("rd_en1", 32'(reg_rd_en1), 32'h1);
    chk("rdaddr1", 32'(reg_rdaddr1), 32'h3);
    chk("rd_en2", 32'(reg_rd_en2), 32'h1);
    chk("rdaddr2", 32'(reg_rdaddr2), 32'h4);
    chk("plain_stall_req", 32'(stall_req), 32'h0);
    step();
    chk("plain_op1", idex_op1, 32'h11);
    chk("plain_op2", idex_op2, 32'h22);
    chk("plain_valid", 32'(idex_valid), 32'h1);
    chk("plain_aluop", 32'(idex_aluop), 32'h20);
    chk("plain_wd", 32'(idex_wd), 32'h6);

    // EX beats MEM
    fwd_ex_wreg = 1; fwd_ex_wd = 3; fwd_ex_wdata = 32'hAAAA;
    fwd_mem_wreg = 1; fwd_mem_wd = 3; fwd_mem_wdata = 32'hBBBB;
    step();
    chk("fwd_ex_op1", idex_op1, 32'hAAAA);
    chk("fwd_ex_op2", idex_op2, 32'h22);
    fwd_ex_wreg = 0;
    step();
    chk("fwd_mem_op1", idex_op1, 32'hBBBB);
    fwd_ex_wreg = 1; fwd_ex_wd = 0; fwd_mem_wd = 0; id_rs_addr = 0;
    step();
    chk("r0_op1", idex_op1, 32'h0);

    // Load-use: EX is LW r5, ID reads r5
    clr_fwd();
    fwd_ex_wreg = 1; fwd_ex_is_load = 1; fwd_ex_wd = 5; fwd_ex_wdata = 32'hDEAD;
    id_rs_addr = 5;
    #1;
    chk("lu_stall_req", 32'(stall_req), 32'h1);
    step();
    chk("lu_bubble_valid", 32'(idex_valid), 32'h0);
    chk("lu_bubble_op1", idex_op1, 32'h0);
    chk("lu_perf", 32'(perf_bubbles), 32'h1);
    clr_fwd();
    fwd_mem_wreg = 1; fwd_mem_wd = 5; fwd_mem_wdata = 32'h1234;
    #1;
    chk("lu_release_stall_req", 32'(stall_req), 32'h0);
    step();
    chk("lu_mem_op1", idex_op1, 32'h1234);
    chk("lu_mem_valid", 32'(idex_valid), 32'h1);
    chk("lu_perf_hold", 32'(perf_bubbles), 32'h1);

    // Immediate masks rt hazard
    clr_fwd();
    fwd_ex_wreg = 1; fwd_ex_is_load = 1; fwd_ex_wd = 5;
    id_rs_addr = 3; id_rt_addr = 5; id_use_imm = 1; id_imm = 32'hFFFF_FFF0;
    reg_rddata1 = 32'h11;
    #1;
    chk("imm_stall_req", 32'(stall_req), 32'h0);
    chk("imm_rd_en2", 32'(reg_rd_en2), 32'h0);
    step();
    chk("imm_op2", idex_op2, 32'hFFFF_FFF0);
    chk("imm_op1", idex_op1, 32'h11);
    chk("imm_valid", 32'(idex_valid), 32'h1);

    // ex_stall holds ID/EX for 3 cycles, capture on release
    clr_fwd();
    ex_stall = 1; id_rs_addr = 4; reg_rddata1 = 32'h77; id_use_imm = 0;
    reg_rddata2 = 32'h99;
    #1;
    chk("stall_req_ex", 32'(stall_req), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_op1", idex_op1, 32'h11);
      chk("stall_hold_op2", idex_op2, 32'hFFFF_FFF0);
    end
    ex_stall = 0;
    step();
    chk("stall_release_op1", idex_op1, 32'h77);
    chk("stall_release_op2", idex_op2, 32'h99);

    // flush with ex_stall
    ex_stall = 1; flush = 1;
    step();
    chk("flush_stall_valid", 32'(idex_valid), 32'h0);
    chk("flush_stall_op1", idex_op1, 32'h0);
    chk("flush_stall_wd", 32'(idex_wd), 32'h0);
    ex_stall = 0;

    // flush with load_use: counter unchanged
    fwd_ex_wreg = 1; fwd_ex_is_load = 1; fwd_ex_wd = 5; id_rs_addr = 5;
    step();
    chk("flush_lu_valid", 32'(idex_valid), 32'h0);
    chk("flush_lu_perf", 32'(perf_bubbles), 32'h1);
    flush = 0; clr_fwd();
    step();
    chk("recap_valid", 32'(idex_valid), 32'h1);

    // Reset mid-stall
    ex_stall = 1; rst = 1;
    step();
    chk("rst_mid_valid", 32'(idex_valid), 32'h0);
    chk("rst_mid_op2", idex_op2, 32'h0);
    chk("rst_mid_aluop", 32'(idex_aluop), 32'h0);
    chk("rst_mid_perf", 32'(perf_bubbles), 32'h0);
    ex_stall = 0; id_valid = 0;
    #1;
    chk("rst_stall_req", 32'(stall_req), 32'h0);
    chk("invalid_rd_en1", 32'(reg_rd_en1), 32'h0);
    rst = 0;

    // Saturation: 2^16 + 5 load-use bubbles
    id_valid = 1; id_rs_addr = 5;
    fwd_ex_wreg = 1; fwd_ex_is_load = 1; fwd_ex_wd = 5;
    step();
    chk("sat_first", 32'(perf_bubbles), 32'h1);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_perf", 32'(perf_bubbles), 32'hFFFF);
    chk("sat_valid", 32'(idex_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
